fre_meas_ctrl: RTL and testbench
================================

FRE_MEAS_CTRL -- requirements
Module: fre_meas_ctrl

Interface
REQ-001 The block SHALL provide parameter GATE_CYCLES, default 33_000_000, the number of lcd_pclk cycles in one gate window (1 s at 33 MHz).
REQ-002 The block SHALL provide parameter CNT_MAX, default 999_999_999, the largest edge count that is displayable.
REQ-003 The block SHALL have port lcd_pclk, input, 1 bit: the single clock for all logic.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port meas_en, input, 1 bit: 1 runs measurements back-to-back; 0 stops them.
REQ-006 The block SHALL have port sig_in, input, 1 bit: the signal under test.
REQ-007 The block SHALL have port data_d0, output, 36 bits: 9-digit BCD frequency, digit 8 in bits [35:32], registered.
REQ-008 The block SHALL have port data_valid, output, 1 bit: one-cycle pulse when data_d0 updates.
REQ-009 The block SHALL have port gate_active, output, 1 bit: high while in GATE.

Function
REQ-010 The state machine SHALL have four states: IDLE, GATE, CONV and DONE.
REQ-011 In IDLE with meas_en=1, the block SHALL enter GATE on the next cycle, clearing the edge counter and the gate counter.
REQ-012 GATE SHALL last exactly GATE_CYCLES cycles; each detected sig_in rising edge in those cycles SHALL increment the 30-bit edge counter by 1.
REQ-013 The edge counter SHALL saturate at 2^30-1 and never wrap.
REQ-014 An edge detected in the same cycle as the GATE->CONV transition SHALL be counted; edges detected during CONV, DONE or IDLE SHALL be ignored.
REQ-015 CONV SHALL perform sequential double-dabble (shift-add-3), one bit per cycle, for exactly 30 cycles, producing 36-bit BCD.
REQ-016 DONE SHALL last 1 cycle, during which data_d0 is loaded and data_valid=1; the next state SHALL be GATE if meas_en=1, otherwise IDLE.
REQ-017 If the final count exceeds CNT_MAX, data_d0 SHALL be 36'hF_0000_0000 (overflow marker; the display averager skips entries whose top nibble is nonzero).
REQ-018 If meas_en falls during GATE or CONV, the block SHALL abort to IDLE on the next cycle, discard the partial result, hold data_d0 and leave data_valid low.
REQ-019 data_d0 SHALL hold its last value between DONE cycles.
REQ-020 Result latency SHALL be GATE_CYCLES + 30 + 1 cycles from GATE entry to data_valid.
REQ-021 gate_active SHALL be a registered decode of state==GATE.

Reset
REQ-022 When sys_rst=1 (asynchronous), the state SHALL be IDLE and data_d0, data_valid, gate_active and all counters, shift registers and synchroniser flops SHALL be 0.
REQ-023 A reset asserted mid-GATE or mid-CONV SHALL discard all work in progress; after release the block SHALL restart from IDLE.

Configuration
REQ-024 With macro FRE_INPUT_SYNC_EN defined, sig_in SHALL pass through a 2-flop synchroniser plus an edge-detect register, giving 3 cycles from sig_in edge to count.
REQ-025 Without FRE_INPUT_SYNC_EN, sig_in SHALL be treated as synchronous with a single edge-detect register, giving 1 cycle from sig_in edge to count; all other behaviour SHALL be identical.

Verification
REQ-026 GATE_CYCLES=100, meas_en=1, sig_in period 4 cycles free-running -> data_valid pulses every 131 cycles with data_d0=36'h0_0000_0025.
REQ-027 GATE_CYCLES=100, CNT_MAX=20, sig_in period 2 -> count 50 > 20 -> data_d0=36'hF_0000_0000 with data_valid pulse.
REQ-028 GATE_CYCLES=100, sig_in held 0 -> data_d0=36'h0_0000_0000; then sig_in period 10 -> next result 36'h0_0000_0010.
REQ-029 meas_en dropped 50 cycles into GATE after one completed result of 36'h0_0000_0025 -> IDLE on the next cycle, no data_valid pulse, data_d0 stays 36'h0_0000_0025.
REQ-030 sys_rst pulsed during CONV -> all outputs 0 immediately; after release with meas_en=1 -> first data_valid occurs 131 cycles after GATE entry.
REQ-031 Double-dabble check via testbench force of the edge counter to 999_999_999 at GATE end -> data_d0=36'h9_9999_9999.

Source files
------------

// File: rtl/fre_meas_ctrl.sv
// Frequency meter controller: counts rising edges of sig_in over a gate
// window of GATE_CYCLES lcd_pclk cycles, converts the count to 9-digit BCD
// with a sequential double-dabble, and presents it on data_d0 with a
// one-cycle data_valid strobe. Counts above CNT_MAX are replaced by the
// overflow marker 36'hF_0000_0000.
// Build option: define FRE_INPUT_SYNC_EN to pass sig_in through a 2-flop
// synchroniser before edge detection (for asynchronous inputs).
module fre_meas_ctrl #(
    parameter int unsigned GATE_CYCLES = 33_000_000,
    parameter int unsigned CNT_MAX     = 999_999_999
) (
    input  logic        lcd_pclk,
    input  logic        sys_rst,
    input  logic        meas_en,
    input  logic        sig_in,
    output logic [35:0] data_d0,
    output logic        data_valid,
    output logic        gate_active
);

    localparam int            GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [29:0]   CNT_SAT   = 30'h3FFF_FFFF;
    localparam logic [4:0]    BIT_LAST  = 5'd29;
    localparam logic [35:0]   OVF_MARK  = 36'hF_0000_0000;

    typedef enum logic [1:0] {IDLE, GATE, CONV, DONE} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gate_cnt_q, gate_cnt_d;
    logic [29:0]   edge_cnt_q, edge_cnt_d;
    logic [29:0]   cnt_final;
    logic [29:0]   bin_q, bin_d;
    logic [35:0]   bcd_q, bcd_d;
    logic [35:0]   bcd_adj;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic          ovf_q, ovf_d;
    logic [35:0]   data_d0_q, data_d0_d;
    logic          data_valid_q, data_valid_d;
    logic          gate_active_q, gate_active_d;
    logic          rise_det;

`ifdef FRE_INPUT_SYNC_EN
    logic sync1_q, sync1_d, sync2_q, sync2_d, sig_prev_q, sig_prev_d;

    // Resynchronise sig_in and flag a rising edge of the synchronised copy
    always_comb begin
        sync1_d    = sig_in;
        sync2_d    = sync1_q;
        sig_prev_d = sync2_q;
        rise_det   = sync2_q & ~sig_prev_q;
    end

    // Synchroniser and edge-detect history flops
    always_ff @(posedge lcd_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sig_prev_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sig_prev_q <= sig_prev_d;
        end
    end
`else
    logic sig_prev_q, sig_prev_d;

    // sig_in is already synchronous: compare against last cycle's sample
    always_comb begin
        sig_prev_d = sig_in;
        rise_det   = sig_in & ~sig_prev_q;
    end

    // Edge-detect history flop
    always_ff @(posedge lcd_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            sig_prev_q <= 1'b0;
        end else begin
            sig_prev_q <= sig_prev_d;
        end
    end
`endif

    // Edge count including this cycle's edge, saturating instead of wrapping
    always_comb begin
        cnt_final = edge_cnt_q;
        if (rise_det && (edge_cnt_q != CNT_SAT)) begin
            cnt_final = edge_cnt_q + 30'd1;
        end
    end

    // Add 3 to every BCD digit of 5 or more ahead of the next shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 9; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath decisions for the gate/convert/publish cycle
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        bit_cnt_d  = bit_cnt_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (meas_en) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end
            end
            GATE: begin
                if (!meas_en) begin
                    state_d = IDLE;
                end else begin
                    edge_cnt_d = cnt_final;
                    gate_cnt_d = gate_cnt_q + GW'(1);
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d   = CONV;
                        bin_d     = cnt_final;
                        bcd_d     = '0;
                        bit_cnt_d = '0;
                        ovf_d     = ({2'b00, cnt_final} > CNT_MAX);
                    end
                end
            end
            CONV: begin
                if (!meas_en) begin
                    state_d = IDLE;
                end else begin
                    bcd_d     = {bcd_adj[34:0], bin_q[29]};
                    bin_d     = {bin_q[28:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (meas_en) begin
                    state_d    = GATE;
                    gate_cnt_d = '0;
                    edge_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        data_valid_d  = (state_d == DONE);
        gate_active_d = (state_d == GATE);
        data_d0_d     = data_d0_q;
        if (state_d == DONE) begin
            data_d0_d = ovf_q ? OVF_MARK : bcd_d;
        end
    end

    // State, counters, conversion registers and registered outputs
    always_ff @(posedge lcd_pclk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            gate_cnt_q    <= '0;
            edge_cnt_q    <= '0;
            bin_q         <= '0;
            bcd_q         <= '0;
            bit_cnt_q     <= '0;
            ovf_q         <= 1'b0;
            data_d0_q     <= '0;
            data_valid_q  <= 1'b0;
            gate_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gate_cnt_q    <= gate_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            bin_q         <= bin_d;
            bcd_q         <= bcd_d;
            bit_cnt_q     <= bit_cnt_d;
            ovf_q         <= ovf_d;
            data_d0_q     <= data_d0_d;
            data_valid_q  <= data_valid_d;
            gate_active_q <= gate_active_d;
        end
    end

    assign data_d0     = data_d0_q;
    assign data_valid  = data_valid_q;
    assign gate_active = gate_active_q;

endmodule

// File: tb/tb_fre_meas_ctrl.sv
// Bench for fre_meas_ctrl with a 100-cycle gate. Two instances share the
// stimulus: one with the default CNT_MAX and one with CNT_MAX=20, so the
// overflow marker and normal results are observed on the same runs.
module tb_fre_meas_ctrl;

    localparam int unsigned G      = 100;
    localparam int unsigned CMAX_A = 999_999_999;
    localparam int unsigned CMAX_B = 20;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        meas_en = 1'b0;
    logic        sig_in  = 1'b0;
    logic [35:0] data_a, data_b;
    logic        valid_a, valid_b, gate_a, gate_b;

    int checks = 0;
    int errors = 0;

    int sig_period = 0;
    int last_period = 0;
    int sig_phase = 0;

    // Reference model state
    bit          busy = 0;
    int unsigned elapsed = 0;
    longint      cnt_a = 0, cnt_b = 0;
    bit          prev_sig = 0;
    logic [35:0] exp_a = '0, exp_b = '0;
    bit          exp_valid = 0, exp_gate = 0;
    bit          force_flag = 0;

    always #5 clk = ~clk;

    fre_meas_ctrl #(.GATE_CYCLES(G), .CNT_MAX(CMAX_A)) dut (
        .lcd_pclk(clk), .sys_rst(rst), .meas_en(meas_en), .sig_in(sig_in),
        .data_d0(data_a), .data_valid(valid_a), .gate_active(gate_a)
    );

    fre_meas_ctrl #(.GATE_CYCLES(G), .CNT_MAX(CMAX_B)) dut_ovf (
        .lcd_pclk(clk), .sys_rst(rst), .meas_en(meas_en), .sig_in(sig_in),
        .data_d0(data_b), .data_valid(valid_b), .gate_active(gate_b)
    );

    // Decimal count to the displayed BCD word, or the overflow marker
    function automatic logic [35:0] to_display(input longint c, input longint cmax);
        logic [35:0] r;
        longint      v;
        if (c > cmax) return 36'hF_0000_0000;
        r = '0;
        v = c;
        for (int i = 0; i < 9; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input int period);
        meas_en    = en;
        sig_period = period;
    endtask

    // Free-running square wave on sig_in, 50% duty, restarting on a period change
    always @(negedge clk) begin
        if (sig_period != last_period) begin
            sig_phase   = 0;
            last_period = sig_period;
        end
        if (sig_period == 0) begin
            sig_in = 1'b0;
        end else begin
            sig_in    = (sig_phase < sig_period / 2);
            sig_phase = (sig_phase + 1) % sig_period;
        end
    end

    // Model: a measurement is a run of G gate cycles, 30 conversion cycles
    // and one publish cycle, timed from the cycle the run started
    always @(posedge clk) begin
        if (rst) begin
            busy = 0; elapsed = 0; cnt_a = 0; cnt_b = 0; prev_sig = 0;
            exp_a = '0; exp_b = '0; exp_valid = 0; exp_gate = 0;
        end else begin
            exp_valid = 0;
            if (busy) begin
                elapsed++;
                if (!meas_en && elapsed <= G + 30) begin
                    busy = 0;
                end else if (elapsed <= G) begin
                    if (sig_in && !prev_sig) begin
                        if (cnt_a < 64'd1073741823) cnt_a++;
                        if (cnt_b < 64'd1073741823) cnt_b++;
                    end
                    if (elapsed == G && force_flag) begin
                        cnt_a      = 999_999_999;
                        force_flag = 0;
                    end
                end else if (elapsed == G + 30) begin
                    exp_valid = 1;
                    exp_a     = to_display(cnt_a, CMAX_A);
                    exp_b     = to_display(cnt_b, CMAX_B);
                end else if (elapsed == G + 31) begin
                    if (meas_en) begin
                        elapsed = 0; cnt_a = 0; cnt_b = 0;
                    end else begin
                        busy = 0;
                    end
                end
            end else if (meas_en) begin
                busy = 1; elapsed = 0; cnt_a = 0; cnt_b = 0;
            end
            exp_gate = busy && (elapsed < G);
            prev_sig = sig_in;
        end
    end

    // Every cycle, away from the clock edge, both instances against the model
    always @(negedge clk) begin
        if (rst) begin
            checkOutput("reset data_a", data_a, 36'h0);
            checkOutput("reset data_b", data_b, 36'h0);
            checkOutput("reset valid", 36'({valid_a, valid_b}), 36'h0);
            checkOutput("reset gate", 36'({gate_a, gate_b}), 36'h0);
        end else begin
            checkOutput("data_a", data_a, exp_a);
            checkOutput("data_b", data_b, exp_b);
            checkOutput("valid_a", 36'(valid_a), 36'(exp_valid));
            checkOutput("valid_b", 36'(valid_b), 36'(exp_valid));
            checkOutput("gate_a", 36'(gate_a), 36'(exp_gate));
            checkOutput("gate_b", 36'(gate_b), 36'(exp_gate));
        end
    end

    task automatic waitGateRise();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (gate_a) return;
        end
        checks++; errors++;
        $display("[TB] FAIL gate timeout: gate_active stayed 0, expected 1");
    endtask

    // Returns the number of clock edges until data_valid is seen
    task automatic waitValid(output int n);
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            n++;
            if (valid_a) return;
        end
        checks++; errors++;
        $display("[TB] FAIL valid timeout: data_valid stayed 0, expected 1");
    endtask

    initial begin
        int n;
        int pulses;

        applyStimulus(0, 0);
        repeat (3) @(posedge clk); #1;
        checkOutput("lit reset data", data_a, 36'h0);
        checkOutput("lit reset valid", 36'(valid_a), 36'h0);
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;
        checkOutput("lit idle gate", 36'(gate_a), 36'h0);

        // Period 4: 25 edges per window; the 20-limit instance overflows
        applyStimulus(1, 4);
        waitGateRise();
        waitValid(n);
        checkOutput("lit first latency", 36'(n + 1), 36'd131);
        checkOutput("lit count 25", data_a, 36'h0_0000_0025);
        checkOutput("lit ovf 25", data_b, 36'hF_0000_0000);
        waitValid(n);
        checkOutput("lit result period", 36'(n), 36'd131);
        checkOutput("lit count 25 again", data_a, 36'h0_0000_0025);

        // Period 2: 50 edges
        applyStimulus(1, 2);
        waitValid(n);
        checkOutput("lit count 50", data_a, 36'h0_0000_0050);
        checkOutput("lit ovf 50", data_b, 36'hF_0000_0000);

        // No edges, then period 10
        applyStimulus(1, 0);
        waitValid(n);
        checkOutput("lit count 0", data_a, 36'h0);
        checkOutput("lit count 0 b", data_b, 36'h0);
        applyStimulus(1, 10);
        waitValid(n);
        checkOutput("lit count 10", data_a, 36'h0_0000_0010);
        checkOutput("lit count 10 b", data_b, 36'h0_0000_0010);

        // Abort 50 cycles into a gate after a completed 25 result
        applyStimulus(1, 4);
        waitValid(n);
        checkOutput("lit pre-abort", data_a, 36'h0_0000_0025);
        waitGateRise();
        repeat (50) @(posedge clk); #1;
        applyStimulus(0, 4);
        @(posedge clk); #1;
        checkOutput("lit abort gate", 36'(gate_a), 36'h0);
        pulses = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (valid_a) pulses++;
        end
        checkOutput("lit abort no valid", 36'(pulses), 36'h0);
        checkOutput("lit abort hold", data_a, 36'h0_0000_0025);

        // Reset pulse during conversion, then a fresh measurement
        applyStimulus(1, 4);
        waitGateRise();
        repeat (G + 10) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("lit rst conv data", data_a, 36'h0);
        checkOutput("lit rst conv valid", 36'(valid_a), 36'h0);
        checkOutput("lit rst conv gate", 36'(gate_a), 36'h0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        waitGateRise();
        waitValid(n);
        checkOutput("lit post-reset latency", 36'(n + 1), 36'd131);
        checkOutput("lit post-reset count", data_a, 36'h0_0000_0025);

        // Largest displayable count loaded at the end of a silent gate
        applyStimulus(1, 0);
        waitValid(n);
        waitGateRise();
        repeat (G - 1) @(posedge clk); #1;
        force dut.edge_cnt_q = 30'd999_999_999;
        force_flag = 1;
        @(posedge clk); #1;
        release dut.edge_cnt_q;
        waitValid(n);
        checkOutput("lit max bcd", data_a, 36'h9_9999_9999);
        checkOutput("lit max bcd b", data_b, 36'h0);

        applyStimulus(0, 0);
        repeat (5) @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
